// File: rtl/rfg_axis_protocol_v2_pkg.sv
// Shared types and constants for the AXI-Stream register-file protocol bridge.
package rfg_axis_protocol_v2_pkg;

    // Request header byte; bit 0 is wr, bit 7:4 is the virtual channel.
    typedef struct packed {
        logic [3:0] vchannel;
        logic       ext;
        logic       incr;
        logic       rd;
        logic       wr;
    } header_t;

    // Encoding is visible on debug_state, so keep values stable.
    typedef enum logic [3:0] {
        S_HEADER = 4'd0,
        S_ADDR   = 4'd1,
        S_LEN0   = 4'd2,
        S_LEN1   = 4'd3,
        S_WRITE  = 4'd4,
        S_ACK    = 4'd5,
        S_READ   = 4'd6,
        S_DRAIN  = 4'd7
    } state_t;

    localparam logic [7:0] ACK_BYTE     = 8'hAC;
    localparam logic [7:0] TIMEOUT_BYTE = 8'hEE;

endpackage

// File: rtl/rfg_axis_protocol_v2_fifo.sv
// Small first-word-fall-through FIFO: head is valid whenever empty is low.
module mini_fwft_fifo #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic              empty,
    output logic              almost_full
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full        = (count == (AWIDTH+1)'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= (AWIDTH+1)'(DEPTH - 1));
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    // An occupied slot is never rewritten, so head holds steady while not popped.
    assign head        = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rfg_axis_protocol_v2.sv
// Byte-stream request decoder driving a register file, with a buffered
// AXI-Stream response path for reads and write acknowledges.
//
// Both streams use strict valid/ready: a byte transfers on a rising edge where
// tvalid && tready; a source never withdraws or changes tdata/tlast while
// tvalid is high and tready is low, and tvalid never waits on tready.
module rfg_axis_protocol_v2
    import rfg_axis_protocol_v2_pkg::*;
#(
    parameter int ADDR_BYTES    = 2,
    parameter int ID_DEST_WIDTH = 8,
    parameter int FIFO_AWIDTH   = 3,
    parameter int READ_TIMEOUT  = 255
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [ID_DEST_WIDTH-1:0] s_axis_tid,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [ID_DEST_WIDTH-1:0] m_axis_tid,
    output logic [ID_DEST_WIDTH-1:0] m_axis_tdest,
    output logic [8*ADDR_BYTES-1:0]  rfg_address,
    output logic [7:0]               rfg_write_value,
    output logic                     rfg_write,
    output logic                     rfg_write_last,
    output logic                     rfg_read,
    input  logic                     rfg_read_valid,
    input  logic [7:0]               rfg_read_value,
    output logic                     timeout_error,
    output logic [3:0]               debug_state
);
    localparam int          AW           = 8 * ADDR_BYTES;
    localparam logic [15:0] TIMEOUT_LAST = 16'(READ_TIMEOUT - 1);

    state_t      state;
    header_t     hdr;
    logic        run;
    logic [2:0]  addr_idx;
    logic [7:0]  len_lo;
    logic [15:0] len_left;   // bytes still to write, or reads still to issue
    logic [15:0] done_left;  // reads still to complete
    logic [15:0] out_left;   // response bytes still to hand over
    logic [15:0] timer;
    logic        outstanding;

    logic        s_hs;
    logic        m_hs;
    logic        rd_complete;
    logic        rd_timeout;
    logic        ack_push;
    logic        fifo_push;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_afull;

    // run holds the input stream off until the first clock after reset release.
    assign s_axis_tready = run && (state inside {S_HEADER, S_ADDR, S_LEN0, S_LEN1, S_WRITE});
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = m_axis_tvalid && m_axis_tready;

    // A read response in the final timeout cycle takes precedence over the timeout.
    assign rd_complete = (state == S_READ) && outstanding
                         && (rfg_read_valid || (timer == TIMEOUT_LAST));
    assign rd_timeout  = rd_complete && !rfg_read_valid;
    assign ack_push    = (state == S_WRITE) && s_hs && (len_left == 16'd1) && hdr.rd;
    assign fifo_push   = rd_complete || ack_push;
    assign fifo_data   = ack_push ? ACK_BYTE : (rfg_read_valid ? rfg_read_value : TIMEOUT_BYTE);

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = !fifo_empty && (out_left == 16'd1);
    assign m_axis_tid    = ID_DEST_WIDTH'(hdr.vchannel);
    assign debug_state   = state;

    mini_fwft_fifo #(
        .AWIDTH (FIFO_AWIDTH),
        .DWIDTH (8)
    ) u_read_fifo (
        .clk         (aclk),
        .rst_n       (aresetn),
        .push        (fifo_push),
        .push_data   (fifo_data),
        .pop         (m_hs),
        .head        (m_axis_tdata),
        .empty       (fifo_empty),
        .almost_full (fifo_afull)
    );

    // Protocol FSM with registered register-file strobes and address.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= S_HEADER;
            hdr             <= '0;
            run             <= 1'b0;
            addr_idx        <= '0;
            len_lo          <= '0;
            len_left        <= '0;
            done_left       <= '0;
            out_left        <= '0;
            timer           <= '0;
            outstanding     <= 1'b0;
            m_axis_tdest    <= '0;
            rfg_address     <= '0;
            rfg_write_value <= '0;
            rfg_write       <= 1'b0;
            rfg_write_last  <= 1'b0;
            rfg_read        <= 1'b0;
            timeout_error   <= 1'b0;
        end else begin
            run            <= 1'b1;
            rfg_write      <= 1'b0;
            rfg_write_last <= 1'b0;
            rfg_read       <= 1'b0;

            // Address advances once the strobe that used it has been presented.
            if ((rfg_write || rfg_read) && hdr.incr) begin
                rfg_address <= rfg_address + 1'b1;
            end
            if (m_hs) begin
                out_left <= out_left - 16'd1;
            end

            case (state)
                S_HEADER: begin
                    if (s_hs && (s_axis_tdata[1:0] != 2'b00)) begin
                        hdr          <= header_t'(s_axis_tdata);
                        m_axis_tdest <= s_axis_tid;
                        addr_idx     <= '0;
                        state        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (s_hs) begin
                        if (hdr.ext) begin
                            for (int b = 0; b < ADDR_BYTES; b++) begin
                                if (addr_idx == 3'(b)) begin
                                    rfg_address[b*8 +: 8] <= s_axis_tdata;
                                end
                            end
                            addr_idx <= addr_idx + 3'd1;
                            if (addr_idx == 3'(ADDR_BYTES - 1)) begin
                                state <= S_LEN0;
                            end
                        end else begin
                            rfg_address <= AW'(s_axis_tdata);
                            state       <= S_LEN0;
                        end
                    end
                end
                S_LEN0: begin
                    if (s_hs) begin
                        len_lo <= s_axis_tdata;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (s_hs) begin
                        if ({s_axis_tdata, len_lo} == 16'd0) begin
                            state <= S_HEADER;
                        end else begin
                            len_left    <= {s_axis_tdata, len_lo};
                            done_left   <= {s_axis_tdata, len_lo};
                            out_left    <= hdr.wr ? 16'd0 : {s_axis_tdata, len_lo};
                            outstanding <= 1'b0;
                            timer       <= '0;
                            state       <= hdr.wr ? S_WRITE : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (s_hs) begin
                        rfg_write       <= 1'b1;
                        rfg_write_value <= s_axis_tdata;
                        rfg_write_last  <= (len_left == 16'd1);
                        len_left        <= len_left - 16'd1;
                        if (len_left == 16'd1) begin
                            if (hdr.rd) begin
                                out_left <= 16'd1;
                                state    <= S_ACK;
                            end else begin
                                state <= S_HEADER;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (m_hs) begin
                        state <= S_HEADER;
                    end
                end
                S_READ: begin
                    if (!outstanding && !fifo_afull && (len_left != 16'd0)) begin
                        rfg_read    <= 1'b1;
                        outstanding <= 1'b1;
                        timer       <= '0;
                        len_left    <= len_left - 16'd1;
                    end
                    if (rd_complete) begin
                        outstanding <= 1'b0;
                        done_left   <= done_left - 16'd1;
                        if (rd_timeout) begin
                            timeout_error <= 1'b1;
                        end
                        if (done_left == 16'd1) begin
                            state <= S_DRAIN;
                        end
                    end else if (outstanding) begin
                        timer <= timer + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && (out_left == 16'd0)) begin
                        state <= S_HEADER;
                    end
                end
                default: state <= S_HEADER;
            endcase
        end
    end

endmodule

// File: doc/rfg_axis_protocol_v2.md
RFG_AXIS_PROTOCOL_V2 -- requirements
Module: rfg_axis_protocol_v2

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 2, number of address bytes in extended mode (1..4); rfg_address width = 8*ADDR_BYTES.
REQ-002 SHALL have parameter ID_DEST_WIDTH, default 8, width of tid/tdest.
REQ-003 SHALL have parameter FIFO_AWIDTH, default 3, read buffer depth = 2**FIFO_AWIDTH bytes.
REQ-004 SHALL have parameter READ_TIMEOUT, default 255, cycles to wait for rfg_read_valid (1..65535).
REQ-005 SHALL have ports: aclk in 1 clock; aresetn in 1 reset; reset is asynchronous and active-low.
REQ-006 SHALL have ports: s_axis_tdata in 8, s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tid in ID_DEST_WIDTH (request byte stream and source port).
REQ-007 SHALL have ports: m_axis_tdata out 8, m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tlast out 1, m_axis_tid out ID_DEST_WIDTH, m_axis_tdest out ID_DEST_WIDTH (response stream).
REQ-008 SHALL have ports: rfg_address out 8*ADDR_BYTES, rfg_write_value out 8, rfg_write out 1, rfg_write_last out 1, rfg_read out 1, rfg_read_valid in 1, rfg_read_value in 8 (register file side).
REQ-009 SHALL have ports: timeout_error out 1 (sticky), debug_state out 4.

Function
REQ-010 Header byte: [0] write, [1] read, [2] address increment, [3] extended address, [7:4] vchannel; header with [1:0]=00 SHALL be consumed and ignored.
REQ-011 States: HEADER, ADDR, LEN0, LEN1, WRITE, ACK, READ, DRAIN; debug_state SHALL equal the state encoding, registered.
REQ-012 HEADER->ADDR on accepted valid header; latch tdest<=s_axis_tid, tid<={0,vchannel}.
REQ-013 ADDR: accepts ADDR_BYTES bytes LSB first if extended, else one byte with upper bytes zero; then LEN0.
REQ-014 LEN0/LEN1: 16-bit length LSB first; length 0 SHALL return to HEADER with no bus activity; otherwise WRITE if write bit set, else READ.
REQ-015 WRITE: each accepted byte drives rfg_write=1 for one cycle, rfg_write_value=byte, rfg_write_last=1 on final byte; address increments after each write when increment bit set.
REQ-016 Header with write and read both set = write-with-ack: after last write byte go to ACK, emit single byte 0xAC with tlast=1, return to HEADER on handshake; otherwise WRITE->HEADER after last byte.
REQ-017 s_axis_tready SHALL be 1 only in HEADER, ADDR, LEN0, LEN1, WRITE.
REQ-018 READ: one outstanding read max; rfg_read pulses one cycle when FIFO not almost-full and no read outstanding; address increments on pulse when increment bit set.
REQ-019 Read completes on rfg_read_valid (push rfg_read_value) or after READ_TIMEOUT cycles without it (push 0xEE, set timeout_error); rfg_read_valid arriving in the same cycle as timeout SHALL win.
REQ-020 After length reads issued and completed, READ->DRAIN; DRAIN->HEADER when FIFO empty and last byte handshaken.
REQ-021 Master stream: tvalid=!fifo_empty; tdata=FIFO head; pop on tvalid&&tready; tlast=1 on the length-th byte only; tdata/tlast SHALL be stable while tvalid&&!tready.
REQ-022 Length counter 16-bit, no wrap; address increments wrap modulo 2**(8*ADDR_BYTES).
REQ-023 timeout_error SHALL clear only on reset.

Reset
REQ-024 On aresetn=0: state HEADER, all strobes 0, tvalid 0, tlast 0, s_axis_tready 0, address/tid/tdest 0, timeout_error 0, FIFO empty, counters 0.
REQ-025 Reset mid-transaction SHALL abort it; no partial response emitted after release.

Structure
REQ-026 Package rfg_axis_protocol_v2_pkg SHALL hold header_t, state enum, ACK_BYTE=8'hAC, TIMEOUT_BYTE=8'hEE.
REQ-027 Read buffer SHALL be one mini_fwft_fifo instance, AWIDTH=FIFO_AWIDTH, DWIDTH=8.

Verification
REQ-028 Write 0x05,addr 0x10,len 3,data 11 22 33 -> rfg_write at 0x10,0x11,0x12, last on 0x33, no response.
REQ-029 Read 0x06,addr 0x20,len 4, tready toggling 50% -> 4 bytes out in order, tlast on 4th, tid=vchannel, tdest=s_axis_tid.
REQ-030 Read len 2, rfg_read_valid never asserted -> two 0xEE bytes after ~2*READ_TIMEOUT cycles, timeout_error=1.
REQ-031 Extended write-ack 0x0B, ADDR_BYTES=3, addr 0x123456, len 1 -> write at 0x123456, then 0xAC with tlast.
REQ-032 Length 0 read, then aresetn pulse during a 16-byte read -> no output for length 0; after reset tvalid=0, state HEADER.
